// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   arb_state_e : arbiter FSM states (idle / memory busy / response pulse)
//   grant_e     : which requester owns the current access
//   BE_WORD     : full-word byte enable, used for every fetch
//   BE_BYTE     : single-byte enable pattern from the decoder masks
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GntNone = 2'd0,
        GntIf   = 2'd1,
        GntD    = 2'd2
    } grant_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_BYTE = 4'b0001;

    // STARVE_LIMIT is bounded to 1..15, so four bits always suffice.
    localparam int unsigned StarveCntW = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Fetch-starvation guard for the memory port arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   d_grant    : data access granted this cycle
//   if_grant   : fetch access granted this cycle
//   if_req     : fetch currently pending
//   starve_cnt : data grants issued while a fetch was waiting
//   force_if   : counter at limit, the next contended grant must go to fetch
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  d_grant,
    input  logic                  if_grant,
    input  logic                  if_req,
    output logic [StarveCntW-1:0] starve_cnt,
    output logic                  force_if
);

    localparam logic [StarveCntW-1:0] Limit = StarveCntW'(STARVE_LIMIT);

    logic [StarveCntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (if_grant) begin
            cnt_d = '0;
        end else if (d_grant && if_req && (cnt_q != Limit)) begin
            cnt_d = cnt_q + StarveCntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starve_cnt = cnt_q;
    assign force_if   = (cnt_q == Limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between instruction fetch and the
// MEM-stage data access. Each access runs IDLE -> BUSY (req/ack) -> RESP
// (one-cycle done pulse), so requests are only resampled after the pipeline
// has reacted to the previous completion.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   if_req/if_addr             : fetch request held until if_done
//   if_rdata/if_done/if_stall  : fetched word, completion pulse, stall to hazard unit
//   d_MemRead/d_MemWrite       : decoder byte masks, nonzero means a data request
//   d_addr/d_wdata             : data address and store data
//   d_rdata/d_done/d_stall     : raw load word, completion pulse, stall to hazard unit
//   mem_req/we/be/addr/wdata   : memory request, held stable while waiting for ack
//   mem_ack/mem_rdata          : memory completion and read data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_done,
    output logic          if_stall,
    input  logic [3:0]    d_MemRead,
    input  logic [3:0]    d_MemWrite,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_done,
    output logic          d_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);

    arb_state_e state_q, state_d;
    grant_e     grant_q, grant_d;

    logic                  d_req;
    logic                  gnt_data;
    logic                  gnt_fetch;
    logic                  force_if;
    logic [StarveCntW-1:0] starve_cnt;

    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   d_rdata_q;

    assign d_req = (|d_MemRead) | (|d_MemWrite);

    // Grant decision, only meaningful in IDLE. Data has priority unless fetch
    // has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        gnt_data  = 1'b0;
        gnt_fetch = 1'b0;
        if (state_q == StIdle) begin
            if (d_req && !(if_req && force_if)) begin
                gnt_data = 1'b1;
            end else if (if_req) begin
                gnt_fetch = 1'b1;
            end
        end
    end

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_grant    (gnt_data),
        .if_grant   (gnt_fetch),
        .if_req     (if_req),
        .starve_cnt (starve_cnt),
        .force_if   (force_if)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_data) begin
                    state_d = StBusy;
                    grant_d = GntD;
                end else if (gnt_fetch) begin
                    state_d = StBusy;
                    grant_d = GntIf;
                end
            end
            StBusy: begin
                if (mem_ack) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
                grant_d = GntNone;
            end
            default: begin
                state_d = StIdle;
                grant_d = GntNone;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= GntNone;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Request attributes are latched at the grant edge so the memory sees
    // stable values for the whole BUSY phase, whatever the requesters do.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
        end else if (gnt_data) begin
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            // A nonzero write mask wins over a simultaneous read mask.
            we_q    <= |d_MemWrite;
            be_q    <= (|d_MemWrite) ? d_MemWrite : d_MemRead;
        end else if (gnt_fetch) begin
            addr_q  <= if_addr;
            wdata_q <= '0;
            we_q    <= 1'b0;
            be_q    <= BE_WORD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if ((state_q == StBusy) && mem_ack) begin
            if (grant_q == GntIf) begin
                if_rdata_q <= mem_rdata;
            end else begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    // Decoded straight from the state register, so reset drops mem_req at once.
    assign mem_req   = (state_q == StBusy);
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_done  = (state_q == StResp) && (grant_q == GntIf);
    assign d_done   = (state_q == StResp) && (grant_q == GntD);
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between instruction fetch (IF) and the MEM-stage data access.
- The MEM-stage access is driven by the 4-bit MemRead/MemWrite byte masks from the decoder.
- Sequences each access through a req/ack handshake to memory and returns a one-cycle done pulse to the requester.
- Drives per-requester stall outputs into the hazard detection unit, which asserts the control-zeroing select.

Parameters:
- AW, 32, address width.
- STARVE_LIMIT, 4, consecutive data grants with IF pending before IF is forced next (1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  AW  fetch address
- if_rdata  out  32  fetched word, valid while if_done=1
- if_done  out  1  one-cycle completion pulse
- if_stall  out  1  if_req & ~if_done, combinational
- d_MemRead  in  4  data read byte mask (1111 word, 0001 byte)
- d_MemWrite  in  4  data write byte mask
- d_addr  in  AW  data address
- d_wdata  in  32  store data
- d_rdata  out  32  raw load data, valid while d_done=1; no sign or zero extension here
- d_done  out  1  one-cycle completion pulse
- d_stall  out  1  d_req & ~d_done, combinational
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables
- mem_addr  out  AW  memory address
- mem_wdata  out  32  memory write data
- mem_ack  in  1  memory completion, may arrive in the same cycle mem_req first rises
- mem_rdata  in  32  read data, valid when mem_ack=1

Behaviour:
- d_req = |d_MemRead | |d_MemWrite.
- If both masks are nonzero, the write wins: mem_we=1, mem_be=d_MemWrite.
- Fetch is always mem_we=0, mem_be=1111.
- FSM states are IDLE, BUSY, RESP. The grant register holds NONE, IF or D.
- IDLE:
  - Only d_req pending: grant D.
  - Only if_req pending: grant IF.
  - Both pending: grant D unless starve_cnt==STARVE_LIMIT, in which case grant IF.
  - On any grant: go to BUSY. At that edge, register address, wdata, we and be; mem_req=1 from the next cycle.
  - No request: stay in IDLE.
- BUSY:
  - mem_req=1; address, data, we and be are held stable.
  - On mem_ack=1: capture mem_rdata into the granted requester's rdata register, go to RESP, and drop mem_req at the same edge.
  - No timeout; waits indefinitely.
- RESP:
  - The granted requester's done=1 for exactly one cycle, then go to IDLE.
  - No new grant is issued in RESP. This guarantees the pipeline has advanced before requests are resampled.
- Minimum latency: request at cycle 0, mem_req at cycle 1; ack in cycle 1 gives done at cycle 2 and IDLE at cycle 3. Back-to-back throughput is one access per 3 cycles.
- starve_cnt:
  - Increments on a D grant while if_req=1, saturating at STARVE_LIMIT.
  - Clears on any IF grant.
  - Holds its value otherwise.
- Request withdrawal while in BUSY is ignored; the access completes.
- Reset (asynchronous, active-low), mid-access included:
  - State=IDLE, grant=NONE, starve_cnt=0.
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - if_done=0, d_done=0, if_rdata=0, d_rdata=0.
  - Memory must tolerate mem_req dropping before ack.
- Stall outputs are combinational and are 0 when the corresponding req=0.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE/BUSY/RESP);
  - grant encoding GNT_NONE=0, GNT_IF=1, GNT_D=2;
  - BE_WORD=4'b1111 and BE_BYTE=4'b0001.
- Sub-module arb_starve_counter owns starve_cnt and force_if.
  - Inputs: clk, rst_n, d_grant, if_grant, if_req.
  - Parameter: STARVE_LIMIT.

Test Plan:
- Reset then idle with no requests -> mem_req=0, both done=0, both stalls=0 indefinitely.
- if_req=1, addr=0x40, mem_ack returned the first cycle mem_req is high, mem_rdata=0xDEADBEEF -> if_done pulses at cycle 2 with if_rdata=0xDEADBEEF; mem_be=1111, mem_we=0.
- Simultaneous if_req and d_MemWrite=0001, d_addr=0x103, d_wdata=0xAB -> D served first (mem_we=1, mem_be=0001); IF served after d_done; if_stall high throughout.
- if_req held high with 5 back-to-back data loads (d_MemRead=1111), STARVE_LIMIT=4 -> grant order D,D,D,D,IF,D; starve_cnt returns to 0 after the IF grant.
- mem_ack delayed 7 cycles in BUSY -> mem_req, addr and be stable for all 7 cycles; done occurs exactly 1 cycle after the ack edge.
- rst_n asserted mid-BUSY -> mem_req falls immediately without a clock edge; after release, a fresh if_req completes normally with starve_cnt=0.
